// File: rtl/modmul_seq.sv
// rtl/modmul_seq.sv - MSB-first double-and-add sequencer driving an external modular adder
module modmul_seq #(
    parameter int               WIDTH   = 256,
    parameter int               TMO_CYC = 1024,
    parameter logic [WIDTH-1:0] INIT    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] mod,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] res,
    output logic             add_en,
    output logic [WIDTH-1:0] add_op1,
    output logic [WIDTH-1:0] add_op2,
    output logic [WIDTH-1:0] add_mod,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_vld
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(TMO_CYC + 1);

    typedef enum logic [2:0] {IDLE, DBL_ISS, DBL_WT, ADD_ISS, ADD_WT, FIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, r_q, r_nxt;
    logic [IW-1:0]    idx_q, idx_nxt;
    logic [CW-1:0]    cnt_q;
    logic             in_wt, tmo;

    assign add_cin = 1'b0;
    assign in_wt   = (state == DBL_WT) || (state == ADD_WT);
    // The timeout fires in the TMO_CYC-th consecutive wait cycle without a result.
    assign tmo     = in_wt && !add_vld && (cnt_q == CW'(TMO_CYC - 1));

    always_comb begin
        state_nxt = state;
        r_nxt     = r_q;
        idx_nxt   = idx_q;
        busy      = (state != IDLE);
        done      = (state == FIN);
        add_en    = (state == DBL_ISS) || (state == ADD_ISS);
        err       = tmo;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DBL_ISS;
                    r_nxt     = '0;
                    idx_nxt   = IW'(WIDTH - 1);
                end
            end
            DBL_ISS: state_nxt = DBL_WT;
            DBL_WT: begin
                if (add_vld) begin
                    r_nxt = add_sum;
                    if (b_q[idx_q]) begin
                        state_nxt = ADD_ISS;
                    end else if (idx_q == '0) begin
                        state_nxt = FIN;
                    end else begin
                        idx_nxt   = idx_q - 1'b1;
                        state_nxt = DBL_ISS;
                    end
                end else if (tmo) begin
                    state_nxt = IDLE;
                end
            end
            ADD_ISS: state_nxt = ADD_WT;
            ADD_WT: begin
                if (add_vld) begin
                    r_nxt = add_sum;
                    if (idx_q == '0) begin
                        state_nxt = FIN;
                    end else begin
                        idx_nxt   = idx_q - 1'b1;
                        state_nxt = DBL_ISS;
                    end
                end else if (tmo) begin
                    state_nxt = IDLE;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            r_q     <= '0;
            idx_q   <= IW'(WIDTH - 1);
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res     <= INIT;
            add_op1 <= INIT;
            add_op2 <= INIT;
            add_mod <= INIT;
        end else begin
            state <= state_nxt;
            r_q   <= r_nxt;
            idx_q <= idx_nxt;
            if (state == IDLE && start) begin
                a_q     <= op_a;
                b_q     <= op_b;
                add_mod <= mod;
            end
            // Operands are loaded on entry to an issue state so they line up with add_en.
            if (state_nxt == DBL_ISS) begin
                add_op1 <= r_nxt;
                add_op2 <= r_nxt;
            end else if (state_nxt == ADD_ISS) begin
                add_op1 <= r_nxt;
                add_op2 <= a_q;
            end
            if (state_nxt == FIN) begin
                res <= r_nxt;
            end
            if (add_en) begin
                cnt_q <= '0;
            end else if (in_wt && !add_vld) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_modmul_seq.sv
// tb/tb_modmul_seq.sv - directed bench for modmul_seq with a fixed-latency mock adder
module tb_modmul_seq;

    localparam int W   = 8;
    localparam int TMO = 16;
    localparam int L   = 3;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] op_a, op_b, mod;
    logic         busy, done, err;
    logic [W-1:0] res;
    logic         add_en, add_cin, add_vld;
    logic [W-1:0] add_op1, add_op2, add_mod, add_sum;

    logic         stall, stray;
    logic [2:0]   pv = '0;
    logic [W-1:0] s0, s1, s2;
    int           cyc = 0;
    int           en_total = 0;
    int           n_assert = 0;
    int           n_fail = 0;

    modmul_seq #(.WIDTH(W), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .mod(mod),
        .busy(busy), .done(done), .err(err), .res(res),
        .add_en(add_en), .add_op1(add_op1), .add_op2(add_op2), .add_mod(add_mod),
        .add_cin(add_cin), .add_sum(add_sum), .add_vld(add_vld)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] msum(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (m == '0) return '0;
        return W'(s % {1'b0, m});
    endfunction

    // Mock adder: result and vld appear L cycles after the add_en cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (add_en === 1'b1) en_total <= en_total + 1;
        pv <= {pv[1:0], (add_en === 1'b1)};
        s0 <= msum(add_op1, add_op2, add_mod);
        s1 <= s0;
        s2 <= s1;
    end
    assign add_vld = (pv[2] & ~stall) | stray;
    assign add_sum = s2;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] p, output int t);
        op_a  = a;
        op_b  = b;
        mod   = p;
        start = 1'b1;
        t     = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int dc, output bit ok);
        ok = 1'b0;
        dc = 0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                ok = 1'b1;
                dc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] p, input int exp_res, input int exp_n);
        int t, dc, e0;
        bit ok;
        start_op(a, b, p, t);
        e0 = en_total;
        check({tag, "_busy_first"}, int'(busy), 1);
        check({tag, "_en_first"}, int'(add_en), 1);
        wait_done(dc, ok);
        check({tag, "_done_seen"}, int'(ok), 1);
        check({tag, "_res"}, int'(res), exp_res);
        check({tag, "_latency"}, dc - t, 1 + exp_n * (L + 1));
        check({tag, "_en_count"}, en_total - e0, exp_n);
        check({tag, "_add_mod"}, int'(add_mod), int'(p));
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int  t, dc, e0, ec;
        bit  ok, saw_done;

        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        mod   = '0;
        stall = 1'b0;
        stray = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_res", int'(res), 0);
        check("rst_add_en", int'(add_en), 0);
        check("rst_add_op1", int'(add_op1), 0);
        check("rst_add_mod", int'(add_mod), 0);
        check("rst_cin", int'(add_cin), 0);
        rst = 1'b0;
        @(negedge clk);

        run_check("m5x7", 8'd5, 8'd7, 8'd13, 9, 11);
        run_check("m250x250", 8'd250, 8'd250, 8'd251, 1, 14);
        run_check("b_zero", 8'd200, 8'd0, 8'd211, 0, 8);
        run_check("a_zero", 8'd0, 8'd255, 8'd13, 0, 16);

        // A second start while busy must not disturb the running request.
        start_op(8'd5, 8'd7, 8'd13, t);
        e0 = en_total;
        repeat (4) @(negedge clk);
        op_a  = 8'd1;
        op_b  = 8'd1;
        mod   = 8'd11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(dc, ok);
        check("ign_done_seen", int'(ok), 1);
        check("ign_res", int'(res), 9);
        check("ign_latency", dc - t, 45);
        check("ign_en_count", en_total - e0, 11);
        check("ign_add_mod", int'(add_mod), 13);
        @(negedge clk);
        check("ign_busy_after", int'(busy), 0);

        run_check("b2b", 8'd3, 8'd4, 8'd7, 5, 9);

        stall = 1'b1;
        start_op(8'd5, 8'd7, 8'd13, t);
        saw_done = 1'b0;
        ok = 1'b0;
        ec = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) saw_done = 1'b1;
            if (err) begin
                ok = 1'b1;
                ec = cyc;
                break;
            end
            @(negedge clk);
        end
        check("tmo_err_seen", int'(ok), 1);
        check("tmo_err_cycle", ec - t, 1 + TMO);
        check("tmo_no_done", int'(saw_done), 0);
        check("tmo_res_kept", int'(res), 5);
        check("tmo_busy_err_cycle", int'(busy), 1);
        @(negedge clk);
        check("tmo_err_pulse", int'(err), 0);
        check("tmo_busy_after", int'(busy), 0);
        stall = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during ADD_WT: the 7th request of 5*7 is the first ADD_ISS.
        start_op(8'd5, 8'd7, 8'd13, t);
        e0 = en_total;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (en_total - e0 == 7) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rstop_reached_add", int'(ok), 1);
        check("rstop_en_count", en_total - e0, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstop_busy", int'(busy), 0);
        check("rstop_add_en", int'(add_en), 0);
        check("rstop_res", int'(res), 0);
        check("rstop_add_mod", int'(add_mod), 0);
        repeat (2) @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_busy", int'(busy), 0);
        check("stray_res", int'(res), 0);
        check("stray_done", int'(done), 0);
        check("stray_add_en", int'(add_en), 0);

        run_check("post_rst", 8'd3, 8'd4, 8'd7, 5, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/modmul_seq.md
Name: modmul_seq

Overview:
- Sequencer for modular multiplication r = a*b mod p, using MSB-first double-and-add.
- Sits directly upstream of the iterative modular adder. It issues one-cycle add requests to the adder, consumes the adder's sum/vld pulse, and repeats until all multiplier bits are processed.
- Provides a start/busy/done handshake to the datapath controller, plus a watchdog error output if the adder stalls.

Parameters:
- WIDTH, 256, operand/modulus width in bits.
- TMO_CYC, 1024, max cycles in a wait state without add_vld before abort.
- INIT, 0, reset value for registered outputs.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- start  input  1  single-cycle request; sampled only in IDLE
- op_a  input  WIDTH  multiplicand; caller guarantees op_a < mod
- op_b  input  WIDTH  multiplier
- mod  input  WIDTH  modulus p; caller guarantees p > 1
- busy  output  1  high from cycle after accepted start until done/err cycle inclusive
- done  output  1  one-cycle pulse; res valid
- err  output  1  one-cycle pulse on adder timeout
- res  output  WIDTH  result, held until next accepted start
- add_en  output  1  one-cycle pulse to adder
- add_op1  output  WIDTH  adder operand 1, valid in add_en cycle
- add_op2  output  WIDTH  adder operand 2, valid in add_en cycle
- add_mod  output  WIDTH  latched p
- add_cin  output  1  tied 0 (addition only)
- add_sum  input  WIDTH  adder result, reduced < p
- add_vld  input  1  adder result pulse

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - outputs busy=0, done=0, err=0, res=0, add_en=0, add_op1=0, add_op2=0, add_mod=0;
  - state=IDLE, accumulator r=0, bit index=WIDTH-1, timeout counter=0.
  - Reset mid-operation aborts immediately with no done or err.
- States: IDLE, DBL_ISS, DBL_WT, ADD_ISS, ADD_WT, FIN.
- IDLE:
  - On start=1: latch a, b, p; clear r; set idx=WIDTH-1; go to DBL_ISS.
  - start in any other state is ignored.
- DBL_ISS: add_en=1, add_op1=r, add_op2=r; go to DBL_WT.
- DBL_WT:
  - add_vld is sampled from the cycle after add_en onward.
  - On add_vld: r<=add_sum. If b[idx]=1 go to ADD_ISS. Otherwise, if idx=0 go to FIN, else decrement idx and go to DBL_ISS.
- ADD_ISS: add_en=1, add_op1=r, add_op2=a; go to ADD_WT.
- ADD_WT: on add_vld, r<=add_sum. If idx=0 go to FIN, else decrement idx and go to DBL_ISS.
- FIN: res<=r, done=1 for one cycle, busy deasserts next cycle; go to IDLE.
- Timeout:
  - Counter of width ceil(log2(TMO_CYC+1)) clears on every add_en and increments in each *_WT cycle without add_vld.
  - When it reaches TMO_CYC: err=1 for one cycle, go to IDLE, res unchanged, no done.
- Signal rules:
  - add_en is never high in two consecutive cycles and never high outside *_ISS.
  - add_vld outside *_WT is ignored.
  - add_op1/add_op2 hold their last value between requests.
- Latency:
  - Adder with fixed latency L (vld L cycles after the en cycle, L>=1).
  - With N = WIDTH + popcount(op_b) transactions, start accepted at cycle T gives done at T + 1 + N*(L+1).
- Boundaries:
  - op_b=0: WIDTH doublings of 0, res=0.
  - op_a=0: res=0.
  - All arithmetic is delegated to the adder. The sequencer performs no comparison or reduction itself, so res<p relies on the adder's contract.

Test Plan:
- WIDTH=8, L=3 mock adder: a=5, b=7, p=13, start at T -> res=9, done at T+1+11*4=T+45, exactly 11 add_en pulses.
- WIDTH=8: a=250, b=250, p=251 -> res=1, done once, busy low the cycle after done.
- WIDTH=8: b=0, a=200, p=211 -> res=0 after 8 doubling transactions with no ADD_ISS. a=0, b=255 -> res=0.
- Second start pulsed while busy -> ignored; result and transaction count match the first request only. Back-to-back start in the cycle after done is accepted.
- Mock adder never asserts vld, TMO_CYC=16 -> err pulse exactly 16 cycles after the first add_en, no done, res keeps its prior value, FSM back in IDLE.
- rst asserted during ADD_WT -> next cycle busy=0, add_en=0, res=0; a stray add_vld afterward has no effect; a new start then completes correctly.
